// File: rtl/gamma_interp_11bit.sv
// Piecewise-linear gamma re-encode over a 33-point double-buffered curve.
// Three-stage pipeline: fetch/bounds, signed slope product, round/shift/clamp.
module gamma_interp_11bit #(
  parameter int OUT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_hs,
  input  logic             i_vs,
  input  logic [4:0]       idx,
  input  logic [10:0]      pixel_in,
  input  logic [10:0]      lowLevel,
  input  logic [10:0]      highLevel,
  input  logic             lut_we,
  input  logic [5:0]       lut_addr,
  input  logic [OUT_W-1:0] lut_wdata,
  input  logic             lut_commit,
  output logic             commit_pending,
  output logic             o_hs,
  output logic             o_vs,
  output logic [OUT_W-1:0] pix_out
);

  localparam int N  = 33;
  localparam int PW = OUT_W + 12;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] C_MAX = SW'((1 << OUT_W) - 1);

  typedef enum logic {
    S_IDLE,
    S_PEND
  } state_t;

  function automatic logic [OUT_W-1:0] ramp(input int k);
    int v;
    v = (k << OUT_W) / 32;
    if (v > (1 << OUT_W) - 1) v = (1 << OUT_W) - 1;
    return v[OUT_W-1:0];
  endfunction

  function automatic logic [3:0] flog2(input logic [10:0] w);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 11; i++)
      if (w[i]) s = 4'(i);
    return s;
  endfunction

  logic [OUT_W-1:0] r_shadow [N];
  logic [OUT_W-1:0] r_active [N];

  state_t r_state;
  state_t w_state_nxt;
  logic   w_copy;
  logic   r_vs_prev;
  logic   w_vs_fall;

  assign w_vs_fall = r_vs_prev & ~i_vs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_vs_prev <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_vs_prev <= i_vs;
    end
  end

  // A commit arriving on the copy cycle re-arms for the next frame.
  always_comb begin
    w_state_nxt = r_state;
    w_copy      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (lut_commit) w_state_nxt = S_PEND;
      end
      S_PEND: begin
        if (w_vs_fall) begin
          w_copy = 1'b1;
          if (!lut_commit) w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  assign commit_pending = (r_state == S_PEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) r_shadow[k] <= ramp(k);
    end else if (lut_we && lut_addr <= 6'd32) begin
      r_shadow[lut_addr] <= lut_wdata;
    end
  end

  // Copy reads shadow before any same-cycle write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) r_active[k] <= ramp(k);
    end else if (w_copy) begin
      for (int k = 0; k < N; k++) r_active[k] <= r_shadow[k];
    end
  end

  logic [5:0]       w_idx0;
  logic [5:0]       w_idx1;
  logic [10:0]      w_d;
  logic [10:0]      w_w;

  assign w_idx0 = {1'b0, idx};
  assign w_idx1 = w_idx0 + 6'd1;
  assign w_d    = pixel_in - lowLevel;
  assign w_w    = highLevel - lowLevel;

  logic [OUT_W-1:0] r_y0_1;
  logic [OUT_W-1:0] r_y1_1;
  logic [10:0]      r_d_1;
  logic [3:0]       r_sh_1;
  logic             r_wz_1;
  logic             r_blank_1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y0_1    <= '0;
      r_y1_1    <= '0;
      r_d_1     <= '0;
      r_sh_1    <= '0;
      r_wz_1    <= 1'b0;
      r_blank_1 <= 1'b1;
    end else begin
      r_y0_1    <= r_active[w_idx0];
      r_y1_1    <= r_active[w_idx1];
      r_d_1     <= w_d;
      r_sh_1    <= flog2(w_w);
      r_wz_1    <= (w_w == 11'd0);
      r_blank_1 <= ~(i_hs & i_vs);
    end
  end

  logic signed [OUT_W:0]  w_dy;
  logic signed [PW-1:0]   w_dy_x;
  logic signed [PW-1:0]   w_d_x;
  logic signed [PW-1:0]   w_p;

  assign w_dy   = $signed({1'b0, r_y1_1}) - $signed({1'b0, r_y0_1});
  assign w_dy_x = w_dy;
  assign w_d_x  = $signed({{(PW-11){1'b0}}, r_d_1});
  assign w_p    = w_dy_x * w_d_x;

  logic signed [PW-1:0] r_p_2;
  logic [OUT_W-1:0]     r_y0_2;
  logic [3:0]           r_sh_2;
  logic                 r_wz_2;
  logic                 r_blank_2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_2     <= '0;
      r_y0_2    <= '0;
      r_sh_2    <= '0;
      r_wz_2    <= 1'b0;
      r_blank_2 <= 1'b1;
    end else begin
      r_p_2     <= w_p;
      r_y0_2    <= r_y0_1;
      r_sh_2    <= r_sh_1;
      r_wz_2    <= r_wz_1;
      r_blank_2 <= r_blank_1;
    end
  end

  logic signed [SW-1:0] w_rnd;
  logic signed [SW-1:0] w_px;
  logic signed [SW-1:0] w_q;
  logic signed [SW-1:0] w_r;
  logic [OUT_W-1:0]     w_pix;

  always_comb begin
    w_rnd = '0;
    if (r_sh_2 != 4'd0) w_rnd = SW'(1) <<< (r_sh_2 - 4'd1);
    w_px = r_p_2;
    w_q  = (w_px + w_rnd) >>> r_sh_2;
    w_r  = w_q + $signed({{(SW-OUT_W){1'b0}}, r_y0_2});
  end

  always_comb begin
    w_pix = '0;
    if (r_blank_2)     w_pix = '0;
    else if (r_wz_2)   w_pix = r_y0_2;
    else if (w_r[SW-1]) w_pix = '0;
    else if (w_r > C_MAX) w_pix = C_MAX[OUT_W-1:0];
    else               w_pix = w_r[OUT_W-1:0];
  end

  logic [2:0]       r_hs_d;
  logic [2:0]       r_vs_d;
  logic [OUT_W-1:0] r_pix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_d <= '0;
      r_vs_d <= '0;
      r_pix  <= '0;
    end else begin
      r_hs_d <= {r_hs_d[1:0], i_hs};
      r_vs_d <= {r_vs_d[1:0], i_vs};
      r_pix  <= w_pix;
    end
  end

  assign o_hs    = r_hs_d[2];
  assign o_vs    = r_vs_d[2];
  assign pix_out = r_pix;

endmodule

// File: tb/tb_gamma_interp_11bit.sv
// Directed-vector bench for gamma_interp_11bit.
// Expected codes are hand-computed from the ramp and written curve entries.
module tb_gamma_interp_11bit;

  logic        clk;
  logic        rst_n;
  logic        i_hs;
  logic        i_vs;
  logic [4:0]  idx;
  logic [10:0] pixel_in;
  logic [10:0] lowLevel;
  logic [10:0] highLevel;
  logic        lut_we;
  logic [5:0]  lut_addr;
  logic [9:0]  lut_wdata;
  logic        lut_commit;
  logic        commit_pending;
  logic        o_hs;
  logic        o_vs;
  logic [9:0]  pix_out;

  int n_tests = 0;
  int n_fail  = 0;

  gamma_interp_11bit #(.OUT_W(10)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_hs           (i_hs),
    .i_vs           (i_vs),
    .idx            (idx),
    .pixel_in       (pixel_in),
    .lowLevel       (lowLevel),
    .highLevel      (highLevel),
    .lut_we         (lut_we),
    .lut_addr       (lut_addr),
    .lut_wdata      (lut_wdata),
    .lut_commit     (lut_commit),
    .commit_pending (commit_pending),
    .o_hs           (o_hs),
    .o_vs           (o_vs),
    .pix_out        (pix_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [4:0] i, input logic [10:0] p,
                       input logic [10:0] lo, input logic [10:0] hi,
                       input logic hs, input logic vs);
    idx       = i;
    pixel_in  = p;
    lowLevel  = lo;
    highLevel = hi;
    i_hs      = hs;
    i_vs      = vs;
  endtask

  task automatic wr(input logic [5:0] a, input logic [9:0] v);
    lut_we    = 1'b1;
    lut_addr  = a;
    lut_wdata = v;
    step(1);
    lut_we    = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    lut_we     = 1'b0;
    lut_addr   = '0;
    lut_wdata  = '0;
    lut_commit = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    step(1);
    check("rst_pix", pix_out, 0);
    check("rst_hs", o_hs, 0);
    check("rst_vs", o_vs, 0);
    check("rst_pend", commit_pending, 0);
    rst_n = 1'b1;
    step(1);

    drive(4, 18, 16, 20, 1, 1);
    step(2);
    check("hs_lat2", o_hs, 0);
    step(1);
    check("ramp_pix", pix_out, 144);
    check("ramp_hs", o_hs, 1);
    check("ramp_vs", o_vs, 1);

    drive(31, 2047, 2046, 2047, 1, 1);
    step(3);
    check("top_d1", pix_out, 1023);
    drive(31, 2046, 2046, 2047, 1, 1);
    step(3);
    check("top_d0", pix_out, 992);

    drive(2, 1, 0, 3, 1, 1);
    step(3);
    check("npow2_w3", pix_out, 80);

    drive(4, 18, 16, 20, 0, 1);
    step(3);
    check("blank_pix", pix_out, 0);
    check("blank_hs", o_hs, 0);
    check("blank_vs", o_vs, 1);

    drive(0, 9, 5, 5, 1, 1);
    step(3);
    check("w0_ramp", pix_out, 0);

    wr(21, 900);
    wr(22, 100);
    wr(0, 77);
    lut_commit = 1'b1;
    step(1);
    lut_commit = 1'b0;
    check("pend_rise", commit_pending, 1);

    drive(21, 383, 382, 510, 1, 1);
    step(100);
    check("pend_hold", commit_pending, 1);
    check("pre_copy", pix_out, 672);

    i_vs      = 1'b0;
    lut_we    = 1'b1;
    lut_addr  = 5;
    lut_wdata = 500;
    step(1);
    lut_we = 1'b0;
    check("pend_fall", commit_pending, 0);

    drive(21, 383, 382, 510, 1, 1);
    step(3);
    check("round_dec", pix_out, 894);
    drive(5, 0, 0, 1, 1, 1);
    step(3);
    check("we_on_copy", pix_out, 160);
    drive(0, 9, 5, 5, 1, 1);
    step(3);
    check("w0_entry0", pix_out, 77);

    lut_commit = 1'b1;
    step(1);
    i_vs = 1'b0;
    step(1);
    lut_commit = 1'b0;
    check("commit_on_copy", commit_pending, 1);
    drive(5, 0, 0, 1, 1, 1);
    step(3);
    check("second_copy", pix_out, 500);
    i_vs = 1'b0;
    step(1);
    check("pend_clear2", commit_pending, 0);

    lut_commit = 1'b1;
    step(1);
    lut_commit = 1'b0;
    drive(21, 383, 382, 510, 1, 1);
    step(3);
    check("pre_rst_pix", pix_out, 894);
    check("pre_rst_pend", commit_pending, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_pix", pix_out, 0);
    check("arst_hs", o_hs, 0);
    check("arst_vs", o_vs, 0);
    check("arst_pend", commit_pending, 0);
    step(1);
    rst_n = 1'b1;
    step(1);
    drive(21, 383, 382, 510, 1, 1);
    step(3);
    check("ramp_back", pix_out, 672);
    i_vs = 1'b0;
    step(1);
    drive(5, 0, 0, 1, 1, 1);
    step(3);
    check("cancelled", pix_out, 160);
    check("cancel_pend", commit_pending, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
